// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D round scheduler: FSM state encoding,
// the fixed channel numbers and helpers that build SPI command words.
package a2d_pkg;

    // Scheduler states, one SPI request/readback pair per channel
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT1 = 3'd2,
        GAP   = 3'd3,
        RDBK  = 3'd4,
        WAIT2 = 3'd5,
        STORE = 3'd6
    } state_t;

    // Physical A2D channel numbers in round order
    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    // Number of channels per round and the index of the last one
    localparam int         NUM_CH   = 4;
    localparam logic [1:0] LAST_IDX = 2'd3;

    // Map round position (0..3) onto the physical channel number
    function automatic logic [2:0] chan_of(input logic [1:0] idx);
        logic [2:0] ch;
        case (idx)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            default: ch = CH_BATT;
        endcase
        return ch;
    endfunction

    // Command word: channel number in bits [13:11], everything else zero
    function automatic logic [15:0] cmd_of(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/rnd_tmr.sv
// Free-running round period counter. tick is high for the single clock in
// which the counter sits at all ones, so one tick per 2^W clocks.
module rnd_tmr #(
    parameter int FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (FAST_SIM != 0) ? 10 : 20;

    logic [W-1:0] cnt;

    // Count continuously; wraps naturally from all ones back to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = &cnt;

endmodule

// File: rtl/a2d_sched.sv
// A2D round scheduler: once per period tick, converts lft_ld, rght_ld,
// steer_pot and batt in that order through an external SPI master, using a
// request transaction followed by a readback transaction per channel.
module a2d_sched
    import a2d_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        rnd_done
);

    state_t      state;
    logic [1:0]  idx;
    logic        pend;
    logic        tick;
    logic [11:0] sample;
    logic [11:0] conv [NUM_CH];

    // The converter returns a 12-bit result; the top nibble carries nothing
    logic unused_rd_bits;
    assign unused_rd_bits = ^rd_data[15:12];

    rnd_tmr #(
        .FAST_SIM (FAST_SIM)
    ) u_rnd_tmr (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Sequencing FSM; wrt/cmd/rnd_done are registered alongside the state
    // so wrt is high exactly in REQ and RDBK and cmd is stable for the pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            pend     <= 1'b0;
            wrt      <= 1'b0;
            cmd      <= 16'h0000;
            rnd_done <= 1'b0;
            sample   <= 12'h000;
        end else begin
            wrt      <= 1'b0;
            rnd_done <= 1'b0;
            // A tick arriving mid-round is remembered once; extras are lost
            if (tick && (state != IDLE)) begin
                pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick || pend) begin
                        state <= REQ;
                        wrt   <= 1'b1;
                        cmd   <= cmd_of(chan_of(idx));
                        pend  <= 1'b0;
                    end
                end
                REQ: begin
                    state <= WAIT1;
                end
                WAIT1: begin
                    if (done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= RDBK;
                    wrt   <= 1'b1;
                end
                RDBK: begin
                    state <= WAIT2;
                end
                WAIT2: begin
                    if (done) begin
                        state    <= STORE;
                        sample   <= rd_data[11:0];
                        rnd_done <= (idx == LAST_IDX);
                    end
                end
                STORE: begin
                    idx <= idx + 2'd1;
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        state <= REQ;
                        wrt   <= 1'b1;
                        cmd   <= cmd_of(chan_of(idx + 2'd1));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One result register per channel, written only in its own STORE cycle
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_conv
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                conv[gi] <= 12'h000;
            end else if ((state == STORE) && (idx == 2'(gi))) begin
                conv[gi] <= sample;
            end
        end
    end

    assign lft_ld    = conv[0];
    assign rght_ld   = conv[1];
    assign steer_pot = conv[2];
    assign batt      = conv[3];

endmodule

// File: tb/tb_a2d_sched.sv
// Scoreboard bench for a2d_sched: an SPI slave model answers transactions,
// expected commands and round results are queued by the sequencer and
// popped by a monitor whenever the DUT pulses wrt or finishes a round.
module tb_a2d_sched;

    typedef struct packed {
        logic [11:0] l;
        logic [11:0] r;
        logic [11:0] s;
        logic [11:0] b;
    } rnd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        rnd_done;

    logic        resp_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] resp_data = 16'h0000;

    assign done    = resp_done | spur_done;
    assign rd_data = spur_done ? 16'hFFFF : resp_data;

    int checks = 0;
    int errors = 0;

    int   chan_num [4] = '{0, 4, 5, 6};
    rnd_t model = '0;

    logic [15:0] exp_cmd_q [$];
    rnd_t        exp_rnd_q [$];
    logic [11:0] rd_q      [$];
    int          dly_q     [$];

    a2d_sched #(
        .FAST_SIM (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .rd_data   (rd_data),
        .wrt       (wrt),
        .cmd       (cmd),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .rnd_done  (rnd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic rnd_t rand_vals();
        rnd_t r;
        r.l = 12'($urandom);
        r.r = 12'($urandom);
        r.s = 12'($urandom);
        r.b = 12'($urandom);
        return r;
    endfunction

    // Queue everything one round should produce: 8 commands, 4 readback
    // words, 8 response delays and the final output values
    task automatic push_round(input rnd_t vals, input int max_dly,
                              input int spec_idx, input int spec_dly);
        logic [11:0] v [4];
        v[0] = vals.l;
        v[1] = vals.r;
        v[2] = vals.s;
        v[3] = vals.b;
        for (int i = 0; i < 4; i++) begin
            exp_cmd_q.push_back(16'(chan_num[i] * 2048));
            exp_cmd_q.push_back(16'(chan_num[i] * 2048));
            rd_q.push_back(v[i]);
        end
        for (int t = 0; t < 8; t++) begin
            dly_q.push_back((t == spec_idx) ? spec_dly : int'($urandom_range(max_dly, 0)));
        end
        exp_rnd_q.push_back(vals);
        model = vals;
    endtask

    task automatic wait_rnd(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rnd_done && n < 6000);
        check(name, rnd_done, 1'b1);
    endtask

    task automatic measure_first_wrt(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wrt && n < 3000);
        check(name, n, 1024);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wrt"}, wrt, 1'b0);
        check({tag, "_cmd"}, cmd, 16'h0000);
        check({tag, "_rnd_done"}, rnd_done, 1'b0);
        check({tag, "_lft"}, lft_ld, 12'h000);
        check({tag, "_rght"}, rght_ld, 12'h000);
        check({tag, "_steer"}, steer_pot, 12'h000);
        check({tag, "_batt"}, batt, 12'h000);
    endtask

    // SPI slave model: answers each wrt with a done pulse after a queued
    // delay, checks cmd stays put while busy and the gap before next wrt
    initial begin : responder
        int   ncyc     = 0;
        int   done_cyc = 0;
        int   wcnt     = 0;
        int   tx       = 0;
        bit   busy     = 0;
        bit   moved    = 0;
        bit   wrt_busy = 0;
        logic [15:0] busy_cmd = '0;
        logic [11:0] val;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                busy      = 0;
                resp_done = 1'b0;
                tx        = 0;
            end else begin
                if (resp_done) resp_done = 1'b0;
                if (busy) begin
                    if (cmd !== busy_cmd) moved = 1;
                    if (wrt) wrt_busy = 1;
                    if (wcnt == 0) begin
                        if (tx % 2 == 1) begin
                            val = (rd_q.size() > 0) ? rd_q.pop_front() : 12'h000;
                            resp_data = {4'($urandom), val};
                        end else begin
                            resp_data = 16'($urandom);
                        end
                        resp_done = 1'b1;
                        busy      = 0;
                        done_cyc  = ncyc;
                        check("cmd_held_until_done", moved, 1'b0);
                        check("no_wrt_while_busy", wrt_busy, 1'b0);
                        tx++;
                    end else begin
                        wcnt--;
                    end
                end else if (wrt) begin
                    if (tx % 8 != 0) check("wrt_gap_after_done", ncyc - done_cyc, 2);
                    busy     = 1;
                    busy_cmd = cmd;
                    moved    = 0;
                    wrt_busy = 0;
                    wcnt     = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                end
            end
        end
    end

    // Monitor: compare each wrt's cmd and each round's outputs to the queues
    initial begin : monitor
        bit   prev_wrt = 0;
        bit   chk_out  = 0;
        int   rnd_no   = 0;
        logic [15:0] ec;
        rnd_t e;
        rnd_t act;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wrt = 0;
                chk_out  = 0;
            end else begin
                if (chk_out) begin
                    act = {lft_ld, rght_ld, steer_pot, batt};
                    if (exp_rnd_q.size() == 0) begin
                        check("unexpected_round", 1'b1, 1'b0);
                    end else begin
                        e = exp_rnd_q.pop_front();
                        rnd_no++;
                        $display("round %0d outputs %h %h %h %h", rnd_no, lft_ld, rght_ld, steer_pot, batt);
                        check("round_outputs", act, e);
                    end
                end
                chk_out = rnd_done;
                if (wrt) begin
                    $display("wrt cmd=%h", cmd);
                    if (exp_cmd_q.size() == 0) begin
                        check("unexpected_wrt", 1'b1, 1'b0);
                    end else begin
                        ec = exp_cmd_q.pop_front();
                        check("wrt_cmd", cmd, ec);
                    end
                    if (prev_wrt) check("wrt_consecutive", 1'b1, 1'b0);
                end
                prev_wrt = wrt;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : sequencer
        rnd_t v;
        rnd_t a;
        int   n;
        int   w;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // First round with fixed readback values
        push_round({12'h123, 12'h456, 12'h789, 12'hABC}, 0, -1, 0);
        rst = 1'b0;
        measure_first_wrt("first_wrt_latency");
        wait_rnd("round1_done");
        @(negedge clk);
        check("rnd_done_single_pulse", rnd_done, 1'b0);

        // Long done on the rght_ld request
        push_round(rand_vals(), 4, 2, 36);
        wait_rnd("slow_done_round");
        @(negedge clk);

        // Spurious done while idle
        repeat (5) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        w = 0;
        repeat (10) begin
            @(negedge clk);
            if (wrt) w++;
        end
        check("idle_spurious_wrt", w, 0);
        a = {lft_ld, rght_ld, steer_pot, batt};
        check("idle_spurious_outputs", a, model);

        // Random rounds
        for (int k = 0; k < 3; k++) begin
            push_round(rand_vals(), 7, -1, 0);
            wait_rnd("random_round");
            @(negedge clk);
        end

        // Stalled round spanning two more ticks: one extra round, one dropped
        push_round(rand_vals(), 300, 0, 300);
        for (int t = 1; t < 8; t++) dly_q[dly_q.size() - 8 + t] = 300;
        push_round(rand_vals(), 3, -1, 0);
        wait_rnd("stalled_round");
        @(negedge clk);
        @(negedge clk);
        check("pending_round_start", wrt, 1'b1);
        wait_rnd("pending_round");
        w = 0;
        repeat (300) begin
            @(negedge clk);
            if (wrt) w++;
        end
        check("third_tick_dropped", w, 0);

        // Reset in WAIT2 of steer_pot
        push_round(rand_vals(), 2, 5, 2000);
        n = 0;
        w = 0;
        while (w < 6 && n < 4000) begin
            @(negedge clk);
            n++;
            if (wrt) w++;
        end
        check("reached_steer_readback", w, 6);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        exp_cmd_q.delete();
        exp_rnd_q.delete();
        rd_q.delete();
        dly_q.delete();
        @(negedge clk);
        @(negedge clk);
        push_round(rand_vals(), 5, -1, 0);
        rst = 1'b0;
        measure_first_wrt("post_reset_latency");
        wait_rnd("post_reset_round");
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
